// File: rtl/led_anim_pkg.sv
// Shared constants and types for the LED animation player.
package led_anim_pkg;

  // Pattern select encoding on the mode input.
  localparam logic [1:0] SWEEP = 2'd0;
  localparam logic [1:0] CHASE = 2'd1;
  localparam logic [1:0] BLINK = 2'd2;
  localparam logic [1:0] OFF   = 2'd3;

  // Step counts for the width-independent patterns; chase runs RED_W steps.
  localparam int unsigned SWEEP_STEPS = 4;
  localparam int unsigned BLINK_STEPS = 2;

  typedef enum logic {
    StIdle,
    StPlay
  } state_e;

endpackage

// File: rtl/tick_gen.sv
// Step-rate divider: one-cycle tick every TICK_DIV enabled clocks.
module tick_gen #(
  parameter int unsigned TICK_DIV = 3_125_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic reload,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LOAD = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick = enable && (cnt_q == '0);

  // Count down while enabled, reload at zero or on request.
  always_ff @(posedge clk) begin
    if (reset || reload) begin
      cnt_q <= LOAD;
    end else if (enable) begin
      cnt_q <= (cnt_q == '0) ? LOAD : cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/led_anim_player.sv
// LED animation player: plays sweep, chase or blink patterns on two LED banks.
module led_anim_player
  import led_anim_pkg::*;
#(
  parameter int unsigned RED_W    = 18,
  parameter int unsigned GRN_W    = 9,
  parameter int unsigned TICK_DIV = 3_125_000,
  parameter int unsigned REPEATS  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             stop,
  output logic [RED_W-1:0] ledr,
  output logic [GRN_W-1:0] ledg,
  output logic             busy,
  output logic             done
);

  localparam int unsigned SW    = $clog2((RED_W > 4) ? RED_W : 4);
  localparam int unsigned CYC_W = (REPEATS > 0) ? $clog2(REPEATS + 1) : 1;
  localparam logic [CYC_W-1:0] REP_C = CYC_W'(REPEATS);

  state_e           state_q;
  logic [1:0]       mode_q;
  logic [SW-1:0]    step_q;
  logic [CYC_W-1:0] cyc_q;

  logic             tick;
  logic             last_step;
  logic             finish;
  logic [SW-1:0]    step_nx;
  logic [CYC_W-1:0] cyc_inc;
  logic [CYC_W-1:0] cyc_nx;
  logic [1:0]       pat_mode;
  logic [SW-1:0]    pat_step;
  logic [RED_W-1:0] red_nx;
  logic [GRN_W-1:0] grn_nx;

  // Sweep bit at distance j from the MSB is lit when j is a multiple of 2^(s+1).
  function automatic logic sweep_lit(input int j, input int s);
    int msk;
    msk = (1 << (s + 1)) - 1;
    return (s < 3) && ((j & msk) == 0);
  endfunction

  function automatic logic [RED_W-1:0] red_pat(input logic [1:0] m, input logic [SW-1:0] s);
    logic [RED_W-1:0] r;
    int sv;
    r  = '0;
    sv = int'(s);
    unique case (m)
      SWEEP: for (int i = 0; i < int'(RED_W); i++) r[i] = sweep_lit(int'(RED_W) - 1 - i, sv);
      CHASE: if (sv < int'(RED_W)) r[int'(RED_W) - 1 - sv] = 1'b1;
      BLINK: if (sv == 0) r = '1;
      OFF:   r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [GRN_W-1:0] grn_pat(input logic [1:0] m, input logic [SW-1:0] s);
    logic [GRN_W-1:0] g;
    int sv;
    g  = '0;
    sv = int'(s);
    unique case (m)
      SWEEP: for (int i = 0; i < int'(GRN_W); i++) g[i] = sweep_lit(int'(GRN_W) - 1 - i, sv);
      CHASE: g[int'(GRN_W) - 1 - (sv % int'(GRN_W))] = 1'b1;
      BLINK: if (sv == 0) g = '1;
      OFF:   g = '0;
    endcase
    return g;
  endfunction

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .enable (state_q == StPlay),
    .reload ((state_q != StPlay) || (start && !stop)),
    .tick   (tick)
  );

  // Next step/cycle values and the pattern that will be registered this edge.
  always_comb begin
    last_step = 1'b0;
    unique case (mode_q)
      SWEEP: last_step = (step_q == SW'(SWEEP_STEPS - 1));
      CHASE: last_step = (step_q == SW'(RED_W - 1));
      BLINK: last_step = (step_q == SW'(BLINK_STEPS - 1));
      OFF:   last_step = 1'b1;
    endcase
    step_nx  = last_step ? '0 : step_q + 1'b1;
    cyc_inc  = cyc_q + 1'b1;
    // Looping forever never advances the cycle count, so it cannot overflow.
    cyc_nx   = (REPEATS == 0) ? cyc_q : cyc_inc;
    finish   = last_step && (REPEATS != 0) && (cyc_inc == REP_C);
    pat_mode = start ? mode : mode_q;
    pat_step = start ? '0 : step_nx;
    red_nx   = red_pat(pat_mode, pat_step);
    grn_nx   = grn_pat(pat_mode, pat_step);
  end

  // Playback FSM with registered LED, busy and done outputs; stop beats start beats tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      mode_q  <= SWEEP;
      step_q  <= '0;
      cyc_q   <= '0;
      ledr    <= '0;
      ledg    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        if (state_q == StPlay) begin
          state_q <= StIdle;
          step_q  <= '0;
          cyc_q   <= '0;
          ledr    <= '0;
          ledg    <= '0;
          busy    <= 1'b0;
        end
      end else if (start) begin
        step_q <= '0;
        cyc_q  <= '0;
        if (mode == OFF) begin
          state_q <= StIdle;
          ledr    <= '0;
          ledg    <= '0;
          busy    <= 1'b0;
        end else begin
          state_q <= StPlay;
          mode_q  <= mode;
          ledr    <= red_nx;
          ledg    <= grn_nx;
          busy    <= 1'b1;
        end
      end else if (tick) begin
        if (finish) begin
          state_q <= StIdle;
          step_q  <= '0;
          cyc_q   <= '0;
          ledr    <= '0;
          ledg    <= '0;
          busy    <= 1'b0;
          done    <= 1'b1;
        end else begin
          step_q <= step_nx;
          if (last_step) cyc_q <= cyc_nx;
          ledr <= red_nx;
          ledg <= grn_nx;
        end
      end
    end
  end

endmodule

// File: tb/tb_led_anim_player.sv
// Directed bench for led_anim_player with REPEATS=1, 2 and 0 instances.
module tb_led_anim_player;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [1:0]  mode = 2'd0;

  logic [17:0] ledr1, ledr2, ledr0;
  logic [8:0]  ledg1, ledg2, ledg0;
  logic        busy1, busy2, busy0;
  logic        done1, done2, done0;

  int total = 0;
  int bad = 0;

  logic [17:0] sw_r [4];
  logic [8:0]  sw_g [4];

  always #5 clk = ~clk;

  led_anim_player #(.RED_W(18), .GRN_W(9), .TICK_DIV(4), .REPEATS(1)) u_rep1 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .stop(stop),
    .ledr(ledr1), .ledg(ledg1), .busy(busy1), .done(done1)
  );

  led_anim_player #(.RED_W(18), .GRN_W(9), .TICK_DIV(4), .REPEATS(2)) u_rep2 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .stop(stop),
    .ledr(ledr2), .ledg(ledg2), .busy(busy2), .done(done2)
  );

  led_anim_player #(.RED_W(18), .GRN_W(9), .TICK_DIV(4), .REPEATS(0)) u_rep0 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .stop(stop),
    .ledr(ledr0), .ledg(ledg0), .busy(busy0), .done(done0)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'd0;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  task automatic do_start(input logic [1:0] m);
    start = 1'b1; mode = m;
    cyc();
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (ledr1 !== 18'd0) begin bad++; $display("FAIL reset_ledr1 got %h want 0", ledr1); end
    total++; if (ledg1 !== 9'd0) begin bad++; $display("FAIL reset_ledg1 got %h want 0", ledg1); end
    total++; if ({busy1, done1} !== 2'b00) begin bad++; $display("FAIL reset_busy_done1 got %b want 00", {busy1, done1}); end
    total++; if ({busy2, done2, busy0, done0} !== 4'b0) begin bad++; $display("FAIL reset_others got %b want 0000", {busy2, done2, busy0, done0}); end
    total++; if ((ledr2 | ledr0) !== 18'd0) begin bad++; $display("FAIL reset_ledr_others got %h want 0", ledr2 | ledr0); end
  endtask

  task automatic test_sweep();
    int st;
    do_reset();
    do_start(2'd0);
    for (int k = 0; k < 16; k++) begin
      st = k / 4;
      total++; if (ledr1 !== sw_r[st]) begin bad++; $display("FAIL sweep_ledr k=%0d got %b want %b", k, ledr1, sw_r[st]); end
      total++; if (ledg1 !== sw_g[st]) begin bad++; $display("FAIL sweep_ledg k=%0d got %b want %b", k, ledg1, sw_g[st]); end
      total++; if ({busy1, done1} !== 2'b10) begin bad++; $display("FAIL sweep_busy_done k=%0d got %b want 10", k, {busy1, done1}); end
      cyc();
    end
    total++; if ({busy1, done1} !== 2'b01) begin bad++; $display("FAIL sweep_finish got %b want 01", {busy1, done1}); end
    total++; if (ledr1 !== 18'd0) begin bad++; $display("FAIL sweep_finish_ledr got %h want 0", ledr1); end
    cyc();
    total++; if ({busy1, done1} !== 2'b00) begin bad++; $display("FAIL sweep_after got %b want 00", {busy1, done1}); end
  endtask

  task automatic test_chase();
    int st;
    logic [17:0] er;
    logic [8:0]  eg;
    do_reset();
    do_start(2'd1);
    for (int k = 0; k < 144; k++) begin
      st = (k / 4) % 18;
      er = 18'd1 << (17 - st);
      eg = 9'd1 << (8 - (st % 9));
      total++; if (ledr2 !== er) begin bad++; $display("FAIL chase_ledr k=%0d got %h want %h", k, ledr2, er); end
      total++; if (ledg2 !== eg) begin bad++; $display("FAIL chase_ledg k=%0d got %h want %h", k, ledg2, eg); end
      total++; if ({busy2, done2} !== 2'b10) begin bad++; $display("FAIL chase_busy_done k=%0d got %b want 10", k, {busy2, done2}); end
      cyc();
    end
    total++; if ({busy2, done2} !== 2'b01) begin bad++; $display("FAIL chase_finish got %b want 01", {busy2, done2}); end
    cyc();
    total++; if (done2 !== 1'b0) begin bad++; $display("FAIL chase_done_once got %b want 0", done2); end
  endtask

  task automatic test_blink_stop();
    logic [17:0] er;
    do_reset();
    do_start(2'd2);
    for (int k = 0; k < 400; k++) begin
      er = (((k / 4) % 2) == 0) ? 18'h3FFFF : 18'h0;
      total++; if (ledr0 !== er) begin bad++; $display("FAIL blink_ledr k=%0d got %h want %h", k, ledr0, er); end
      total++; if ({busy0, done0} !== 2'b10) begin bad++; $display("FAIL blink_busy_done k=%0d got %b want 10", k, {busy0, done0}); end
      if (k == 399) stop = 1'b1;
      cyc();
    end
    stop = 1'b0;
    total++; if (ledr0 !== 18'd0) begin bad++; $display("FAIL blink_stop_ledr got %h want 0", ledr0); end
    total++; if ({busy0, done0} !== 2'b00) begin bad++; $display("FAIL blink_stop_busy_done got %b want 00", {busy0, done0}); end
    cyc();
    total++; if (done0 !== 1'b0) begin bad++; $display("FAIL blink_stop_done_later got %b want 0", done0); end
  endtask

  task automatic test_restart();
    logic [17:0] er;
    do_reset();
    do_start(2'd0);
    for (int k = 0; k < 9; k++) cyc();
    total++; if (ledr1 !== sw_r[2]) begin bad++; $display("FAIL restart_pre got %b want %b", ledr1, sw_r[2]); end
    do_start(2'd2);
    total++; if (ledr1 !== 18'h3FFFF) begin bad++; $display("FAIL restart_ledr got %h want 3ffff", ledr1); end
    total++; if (ledg1 !== 9'h1FF) begin bad++; $display("FAIL restart_ledg got %h want 1ff", ledg1); end
    total++; if ({busy1, done1} !== 2'b10) begin bad++; $display("FAIL restart_busy_done got %b want 10", {busy1, done1}); end
    for (int k = 1; k < 8; k++) begin
      cyc();
      er = (k < 4) ? 18'h3FFFF : 18'h0;
      total++; if (ledr1 !== er) begin bad++; $display("FAIL restart_blink k=%0d got %h want %h", k, ledr1, er); end
      total++; if (done1 !== 1'b0) begin bad++; $display("FAIL restart_no_done k=%0d got %b want 0", k, done1); end
    end
    cyc();
    total++; if ({busy1, done1} !== 2'b01) begin bad++; $display("FAIL restart_finish got %b want 01", {busy1, done1}); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    do_start(2'd0);
    for (int k = 0; k < 5; k++) cyc();
    total++; if (ledr1 !== sw_r[1]) begin bad++; $display("FAIL rstmid_pre got %b want %b", ledr1, sw_r[1]); end
    reset = 1'b1; start = 1'b1; mode = 2'd0;
    cyc();
    reset = 1'b0; start = 1'b0;
    total++; if ({ledr1, ledg1} !== 27'd0) begin bad++; $display("FAIL rstmid_leds got %h want 0", {ledr1, ledg1}); end
    total++; if ({busy1, done1} !== 2'b00) begin bad++; $display("FAIL rstmid_busy_done got %b want 00", {busy1, done1}); end
    cyc();
    total++; if ({busy1, done1, ledr1} !== 20'd0) begin bad++; $display("FAIL rstmid_start_ignored got %h want 0", {busy1, done1, ledr1}); end
  endtask

  task automatic test_off_and_stopstart();
    do_reset();
    do_start(2'd3);
    total++; if ({busy1, done1, ledr1, ledg1} !== 29'd0) begin bad++; $display("FAIL off_idle got %h want 0", {busy1, done1, ledr1, ledg1}); end
    start = 1'b1; stop = 1'b1; mode = 2'd0;
    cyc();
    start = 1'b0; stop = 1'b0;
    total++; if ({busy1, done1, ledr1, ledg1} !== 29'd0) begin bad++; $display("FAIL stopstart_idle got %h want 0", {busy1, done1, ledr1, ledg1}); end
    cyc();
    total++; if ({busy1, done1} !== 2'b00) begin bad++; $display("FAIL stopstart_later got %b want 00", {busy1, done1}); end
    do_start(2'd0);
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL off_pre_play got %b want 1", busy1); end
    do_start(2'd3);
    total++; if ({busy1, done1, ledr1, ledg1} !== 29'd0) begin bad++; $display("FAIL off_from_play got %h want 0", {busy1, done1, ledr1, ledg1}); end
    cyc();
    total++; if (done1 !== 1'b0) begin bad++; $display("FAIL off_no_done got %b want 0", done1); end
  endtask

  initial begin
    sw_r = '{18'b101010101010101010, 18'b100010001000100010, 18'b100000001000000010, 18'b0};
    sw_g = '{9'b101010101, 9'b100010001, 9'b100000001, 9'b0};
    test_reset();
    test_sweep();
    test_chase();
    test_blink_stop();
    test_restart();
    test_reset_mid();
    test_off_and_stopstart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
